hbridge_deadtime_ctrl: RTL and testbench

//  Registered gate-command generator for one full H-bridge (legs A and B).

---
 rtl/hbridge_deadtime_ctrl.sv | 128 ++++++++++++
 tb/tb_hbridge_deadtime_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hbridge_deadtime_ctrl.sv
// hbridge_deadtime_ctrl: registered gate-command generator for a full H-bridge.
// Turns a 2-bit motor command into PMOS/NMOS gate drives for legs A (bit0) and B (bit1),
// and inserts DEAD_CYCLES of all-off float time between any two driven states.
// Optional feature macro: HB_PWM_EN adds a pwm_in input that chops the command to COAST.
module hbridge_deadtime_ctrl #(
  parameter int unsigned DEAD_CYCLES = 4,
  parameter int unsigned DEAD_W      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] cmd,
`ifdef HB_PWM_EN
  input  logic       pwm_in,
`endif
  output logic [1:0] p_out,
  output logic [1:0] n_out,
  output logic [1:0] applied_cmd,
  output logic       busy
);

  localparam logic [0:0] ST_ON   = 1'b0;
  localparam logic [0:0] ST_DEAD = 1'b1;

  localparam logic [1:0] CMD_COAST   = 2'b00;
  localparam logic [1:0] CMD_FORWARD = 2'b01;
  localparam logic [1:0] CMD_REVERSE = 2'b10;
  localparam logic [1:0] CMD_BRAKE   = 2'b11;

  localparam logic [DEAD_W-1:0] CNT_RELOAD = DEAD_W'(DEAD_CYCLES - 1);

  logic [0:0]        state, state_nxt;
  logic [1:0]        pending, pending_nxt;
  logic [DEAD_W-1:0] cnt, cnt_nxt;
  logic [1:0]        p_nxt, n_nxt, applied_nxt;
  logic              busy_nxt;
  logic [1:0]        eff_c;

  // Gate pattern {p_out, n_out} for a command; PMOS on at 0, NMOS on at 1.
  function automatic logic [3:0] drive(input logic [1:0] c);
    case (c)
      CMD_FORWARD: drive = {2'b10, 2'b10};
      CMD_REVERSE: drive = {2'b01, 2'b01};
      CMD_BRAKE:   drive = {2'b11, 2'b11};
      default:     drive = {2'b11, 2'b00};
    endcase
  endfunction

  // Effective command after enable (and optional PWM) gating.
`ifdef HB_PWM_EN
  always_comb begin
    eff_c = CMD_COAST;
    if (enable) begin
      if (cmd == CMD_BRAKE) eff_c = CMD_BRAKE;
      else if (pwm_in)      eff_c = cmd;
    end
  end
`else
  always_comb begin
    eff_c = enable ? cmd : CMD_COAST;
  end
`endif

  // Next-state and next-output logic for the ON/DEAD sequencer.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    cnt_nxt     = cnt;
    p_nxt       = p_out;
    n_nxt       = n_out;
    applied_nxt = applied_cmd;
    busy_nxt    = busy;
    case (state)
      ST_ON: begin
        if (eff_c != applied_cmd) begin
          if (applied_cmd == CMD_COAST) begin
            // Bridge already floats: no dead time needed.
            applied_nxt    = eff_c;
            {p_nxt, n_nxt} = drive(eff_c);
          end else begin
            state_nxt      = ST_DEAD;
            {p_nxt, n_nxt} = drive(CMD_COAST);
            applied_nxt    = CMD_COAST;
            busy_nxt       = 1'b1;
            pending_nxt    = eff_c;
            cnt_nxt        = CNT_RELOAD;
          end
        end
      end
      default: begin
        if (eff_c != pending) begin
          // Command moved again: dead time counts from the latest change.
          pending_nxt = eff_c;
          cnt_nxt     = CNT_RELOAD;
        end else if (cnt == '0) begin
          state_nxt      = ST_ON;
          applied_nxt    = pending;
          {p_nxt, n_nxt} = drive(pending);
          busy_nxt       = 1'b0;
        end else begin
          cnt_nxt = cnt - DEAD_W'(1);
        end
      end
    endcase
  end

  // State and output registers; reset forces the bridge to float immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_ON;
      pending     <= CMD_COAST;
      cnt         <= '0;
      p_out       <= 2'b11;
      n_out       <= 2'b00;
      applied_cmd <= CMD_COAST;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      cnt         <= cnt_nxt;
      p_out       <= p_nxt;
      n_out       <= n_nxt;
      applied_cmd <= applied_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_hbridge_deadtime_ctrl.sv
// Directed bench for hbridge_deadtime_ctrl (DEAD_CYCLES=4). Table vectors plus
// hand-written reset and PWM sequences, with a continuous gate-safety monitor.
module tb_hbridge_deadtime_ctrl;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [1:0] cmd;
  logic [1:0] p_out, n_out, applied_cmd;
  logic       busy;
`ifdef HB_PWM_EN
  logic       pwm_in;
`endif

  int checks;
  int errors;

  hbridge_deadtime_ctrl #(.DEAD_CYCLES(4), .DEAD_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .cmd         (cmd),
`ifdef HB_PWM_EN
    .pwm_in      (pwm_in),
`endif
    .p_out       (p_out),
    .n_out       (n_out),
    .applied_cmd (applied_cmd),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [1:0] c;
    logic [1:0] p;
    logic [1:0] n;
    logic [1:0] a;
    logic       b;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic [1:0] c, logic [1:0] p, logic [1:0] n,
                              logic [1:0] a, logic b);
    vec_t v;
    v.en = en; v.c = c; v.p = p; v.n = n; v.a = a; v.b = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [1:0] ep, input logic [1:0] en_,
                     input logic [1:0] ea, input logic eb);
    checks++;
    if (p_out !== ep || n_out !== en_ || applied_cmd !== ea || busy !== eb) begin
      errors++;
      $display("FAIL %s: got p=%b n=%b applied=%b busy=%b, expected p=%b n=%b applied=%b busy=%b",
               name, p_out, n_out, applied_cmd, busy, ep, en_, ea, eb);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: no shoot-through and no driven->driven change without passing through float.
  logic [1:0] prev_p, prev_n;
  logic       mon_on;
  initial mon_on = 1'b0;
  always @(negedge clock) begin
    if (mon_on && !reset) begin
      checks++;
      if (((~p_out) & n_out) != 2'b00) begin
        errors++;
        $display("FAIL shoot_through: got p=%b n=%b, expected no leg with p=0 n=1", p_out, n_out);
      end
      if (!(prev_p == 2'b11 && prev_n == 2'b00) && !(p_out == 2'b11 && n_out == 2'b00) &&
          (p_out != prev_p || n_out != prev_n)) begin
        errors++;
        $display("FAIL skip_dead: got %b/%b -> %b/%b, expected float between driven states",
                 prev_p, prev_n, p_out, n_out);
      end
    end
    prev_p = reset ? 2'b11 : p_out;
    prev_n = reset ? 2'b00 : n_out;
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    enable = 1'b0;
    cmd    = 2'b00;
`ifdef HB_PWM_EN
    pwm_in = 1'b1;
`endif

    // Vectors: inputs held across the next edge, outputs expected just after it.
    vecs.push_back(mk(1, 2'b00, 2'b11, 2'b00, 2'b00, 0)); // idle
    vecs.push_back(mk(1, 2'b01, 2'b10, 2'b10, 2'b01, 0)); // COAST->FWD, 1 cycle
    vecs.push_back(mk(1, 2'b01, 2'b10, 2'b10, 2'b01, 0)); // hold
    vecs.push_back(mk(1, 2'b10, 2'b11, 2'b00, 2'b00, 1)); // dead cnt3
    vecs.push_back(mk(1, 2'b10, 2'b11, 2'b00, 2'b00, 1)); // dead cnt2
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b00, 2'b00, 1)); // restart
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b11, 2'b11, 0)); // BRAKE
    vecs.push_back(mk(1, 2'b10, 2'b11, 2'b00, 2'b00, 1)); // BRAKE->REV
    vecs.push_back(mk(1, 2'b10, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2'b10, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2'b10, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2'b10, 2'b01, 2'b01, 2'b10, 0)); // REVERSE
    vecs.push_back(mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 1)); // disable
    vecs.push_back(mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 0)); // COAST after dead
    vecs.push_back(mk(1, 2'b10, 2'b01, 2'b01, 2'b10, 0)); // re-enable, 1 cycle
    vecs.push_back(mk(1, 2'b00, 2'b11, 2'b00, 2'b00, 1)); // REV->COAST
    vecs.push_back(mk(1, 2'b00, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2'b00, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2'b00, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2'b00, 2'b11, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 2'b01, 2'b11, 2'b00, 2'b00, 0)); // disabled ignores cmd
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b11, 2'b11, 0)); // COAST->BRAKE direct

    // Reset is asynchronous: outputs valid before the first edge.
    #2;
    chk("reset_initial", 2'b11, 2'b00, 2'b00, 1'b0);
    step();
    chk("reset_held", 2'b11, 2'b00, 2'b00, 1'b0);
    #2 reset = 1'b0;
    mon_on = 1'b1;

    foreach (vecs[i]) begin
      enable = vecs[i].en;
      cmd    = vecs[i].c;
      step();
      chk($sformatf("vec%0d", i), vecs[i].p, vecs[i].n, vecs[i].a, vecs[i].b);
    end

    // Reset asserted mid-DEAD takes effect without a clock edge.
    cmd = 2'b01;
    step();
    chk("enter_dead", 2'b11, 2'b00, 2'b00, 1'b1);
    step();
    chk("mid_dead", 2'b11, 2'b00, 2'b00, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_dead_async", 2'b11, 2'b00, 2'b00, 1'b0);
    step();
    #2 reset = 1'b0;
    cmd = 2'b00;
    step();
    chk("after_reset_release", 2'b11, 2'b00, 2'b00, 1'b0);
    cmd = 2'b01;
    step();
    chk("after_reset_fwd", 2'b10, 2'b10, 2'b01, 1'b0);

`ifdef HB_PWM_EN
    // PWM chopping on FORWARD: high phase drives, low phase floats 4 busy cycles then coasts.
    begin
      int drv_cnt;
      int busy_cnt;
      for (int ph = 0; ph < 4; ph++) begin
        pwm_in   = ph[0] ? 1'b1 : 1'b0;
        drv_cnt  = 0;
        busy_cnt = 0;
        for (int k = 0; k < 10; k++) begin
          step();
          if (p_out == 2'b10 && n_out == 2'b10) drv_cnt++;
          if (busy) busy_cnt++;
        end
        checks++;
        if (ph[0] ? (drv_cnt != 10 || busy_cnt != 0) : (drv_cnt != 0 || busy_cnt != 4)) begin
          errors++;
          $display("FAIL pwm_phase%0d: got driven=%0d busy=%0d, expected driven=%0d busy=%0d",
                   ph, drv_cnt, busy_cnt, ph[0] ? 10 : 0, ph[0] ? 0 : 4);
        end
      end
      // BRAKE ignores pwm_in once applied.
      cmd = 2'b11;
      for (int k = 0; k < 6; k++) step();
      for (int k = 0; k < 20; k++) begin
        pwm_in = (k % 4 < 2) ? 1'b0 : 1'b1;
        step();
        chk($sformatf("pwm_brake%0d", k), 2'b11, 2'b11, 2'b11, 1'b0);
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
